// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply unit.
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-and-add datapath: one partial-product accumulation per step.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             accumulate,
  output logic [WIDTH-1:0] prod,
  output logic             last_c
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcnd;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnd <= '0;
      mplr <= '0;
      prod <= '0;
      cnt  <= '0;
    end else if (load) begin
      mcnd <= a;
      mplr <= b;
      prod <= accumulate ? acc : '0;
      cnt  <= '0;
    end else if (step) begin
      if (mplr[0]) prod <= prod + mcnd;
      mcnd <= mcnd << 1;
      mplr <= mplr >> 1;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Finish early once no multiplier bits remain above the current one.
  assign last_c = (cnt == CNT_W'(WIDTH - 1)) || ((mplr >> 1) == '0);

endmodule

// File: rtl/iter_mul_unit.sv
// Iterative MUL/MLA unit: control FSM and flag generation around mul_datapath.
module iter_mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             accumulate,
  input  logic             set_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic [1:0]       flag_write
);

  state_t     state;
  state_t     state_nxt;
  logic       sf_q;
  logic       load;
  logic       step;
  logic       last_c;
  logic       busy_nxt;
  logic       done_nxt;
  logic [1:0] flag_write_nxt;

  assign load = (state == IDLE) && start && !flush;
  assign step = (state == RUN) && !flush;

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .a          (a),
    .b          (b),
    .acc        (acc),
    .accumulate (accumulate),
    .prod       (result),
    .last_c     (last_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush wins over everything, including a start in the same cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (last_c) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    flag_write_nxt = 2'b00;
    if (state_nxt != IDLE) busy_nxt = 1'b1;
    if (state_nxt == DONE) begin
      done_nxt = 1'b1;
      if (sf_q) flag_write_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      flag_write <= 2'b00;
      sf_q       <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      done       <= done_nxt;
      flag_write <= flag_write_nxt;
      if (load) sf_q <= set_flags;
    end
  end

  // Only N and Z are meaningful for a multiply; C and V read as zero.
  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = result[WIDTH-1];
    alu_flags[FLAG_Z] = (result == '0);
    alu_flags[FLAG_C] = 1'b0;
    alu_flags[FLAG_V] = 1'b0;
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: directed table, random ops, flush and reset sequences.
module tb_iter_mul_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [W-1:0] a, b, acc;
  logic         accumulate;
  logic         set_flags;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   alu_flags;
  logic [1:0]   flag_write;

  int n_checks = 0;
  int n_fail   = 0;

  iter_mul_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .acc        (acc),
    .accumulate (accumulate),
    .set_flags  (set_flags),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_flags  (alu_flags),
    .flag_write (flag_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         accumulate;
    logic         set_flags;
    logic [W-1:0] exp_res;
    int           exp_k;
    logic [3:0]   exp_flags;
    logic [1:0]   exp_fw;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic product, iteration count from highest set bit of b.
  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [W-1:0] macc, input logic macc_en,
                                 input logic msf);
    vec_t v;
    logic [2*W-1:0] full;
    v.a = ma; v.b = mb; v.acc = macc; v.accumulate = macc_en; v.set_flags = msf;
    full = 64'(ma) * 64'(mb) + (macc_en ? 64'(macc) : 64'd0);
    v.exp_res = full[W-1:0];
    v.exp_k = 1;
    for (int i = 0; i < int'(W); i++) if (mb[i]) v.exp_k = i + 1;
    v.exp_flags = {v.exp_res[W-1], v.exp_res == '0, 2'b00};
    v.exp_fw = msf ? 2'b10 : 2'b00;
    return v;
  endfunction

  // Caller sits just after a posedge; the next posedge is the start edge.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    bit seen;
    a = v.a; b = v.b; acc = v.acc; accumulate = v.accumulate; set_flags = v.set_flags;
    start = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    lat = 0;
    for (int n = 1; n <= int'(W) + 4; n++) begin
      // Junk on inputs and stray starts while busy must have no effect.
      a = $urandom; b = $urandom; acc = $urandom;
      accumulate = 1'($urandom); set_flags = 1'($urandom);
      start = 1'($urandom);
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({name, " latency"}, 64'(lat), 64'(v.exp_k));
      check({name, " result"}, 64'(result), 64'(v.exp_res));
      check({name, " alu_flags"}, 64'(alu_flags), 64'(v.exp_flags));
      check({name, " flag_write"}, 64'(flag_write), 64'(v.exp_fw));
      check({name, " busy_in_done"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      check({name, " done_pulse"}, 64'({done, busy, flag_write}), 64'd0);
      @(posedge clk); #1;
      check({name, " result_hold"}, 64'(result), 64'(v.exp_res));
    end
  endtask

  initial begin
    vec_t v;
    bit bad;
    vecs[0] = model(32'd3, 32'd5, 32'd0, 1'b0, 1'b1);
    vecs[1] = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    vecs[2] = model(32'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    vecs[3] = model(32'd7, 32'd0, 32'd0, 1'b0, 1'b1);
    vecs[4] = model(32'd0, 32'h1234, 32'h55, 1'b1, 1'b1);
    vecs[5] = model(32'h4000_0000, 32'd2, 32'd0, 1'b0, 1'b1);
    // Hand-derived values for the headline cases.
    vecs[0].exp_res = 32'd15; vecs[0].exp_k = 3; vecs[0].exp_flags = 4'b0000;
    vecs[1].exp_res = 32'd1;  vecs[1].exp_k = 32; vecs[1].exp_fw = 2'b00;
    vecs[2].exp_res = 32'd0;  vecs[2].exp_k = 32; vecs[2].exp_flags = 4'b0100;
    vecs[3].exp_res = 32'd0;  vecs[3].exp_k = 1;  vecs[3].exp_flags = 4'b0100;
    vecs[5].exp_res = 32'h8000_0000; vecs[5].exp_k = 2; vecs[5].exp_flags = 4'b1000;

    reset = 1'b0; start = 1'b0; flush = 1'b0;
    a = '0; b = '0; acc = '0; accumulate = 1'b0; set_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, flag_write}), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(alu_flags), 64'(4'b0100));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] rb;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      v = model($urandom, rb, $urandom, 1'($urandom), 1'($urandom));
      run_op(v, $sformatf("rand%0d", i));
    end

    // Flush with a simultaneous start at the 5th RUN edge.
    a = 32'd3; b = 32'h0000_FFFF; accumulate = 1'b0; set_flags = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_idle", 64'({busy, done, flag_write}), 64'd0);
    check("flush_partial", 64'(result == 32'd45 || result == 32'd93), 64'd1);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1;
    end
    check("flush_no_done", 64'(bad), 64'd0);
    run_op(model(32'd2, 32'd2, 32'd0, 1'b0, 1'b1), "after_flush");
    check("after_flush_value", 64'(result), 64'd4);

    // Asynchronous reset in the middle of a long operation.
    a = $urandom; b = 32'hFFFF_FFFF; accumulate = 1'b0; set_flags = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({busy, done, flag_write}), 64'd0);
    check("midrun_reset_result", 64'(result), 64'd0);
    check("midrun_reset_flags", 64'(alu_flags), 64'(4'b0100));
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1;
    end
    check("post_reset_no_done", 64'(bad), 64'd0);
    run_op(model(32'hDEAD, 32'h0BEEF, 32'h10, 1'b1, 1'b1), "post_reset_op");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/iter_mul_unit.md
ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port flush  in  1  abort any operation in progress.
REQ-006 SHALL have ports a, b, acc  in  WIDTH each  multiplicand, multiplier, accumulate addend.
REQ-007 SHALL have port accumulate  in  1  1 = MLA (acc added), 0 = MUL.
REQ-008 SHALL have port set_flags  in  1  instruction S bit.
REQ-009 SHALL have port busy  out  1  high in RUN and DONE; drives pipeline stall.
REQ-010 SHALL have port done  out  1  one-cycle result-valid pulse.
REQ-011 SHALL have port result  out  WIDTH  low WIDTH bits of a*b (+acc).
REQ-012 SHALL have port alu_flags  out  4  {N,Z,C,V} for the flag register.
REQ-013 SHALL have port flag_write  out  2  bit1 = write N,Z; bit0 = write C,V.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE with start=1, flush=0 at an edge SHALL load mcnd=a, mplr=b, prod=(accumulate ? acc : 0), cnt=0, latch set_flags, and go to RUN.
REQ-016 Each RUN edge SHALL do one iteration: if mplr[0], prod += mcnd (mod 2^WIDTH); mcnd <<= 1; mplr >>= 1; cnt += 1.
REQ-017 RUN SHALL go to DONE on the iteration edge where cnt == WIDTH-1 or the shifted mplr is zero.
REQ-018 Iteration count k SHALL therefore be max(1, index of the highest set bit of b + 1), range 1..WIDTH.
REQ-019 done SHALL be 1 only in DONE, i.e. the cycle after the k-th iteration edge (k+1 edges after the start edge); DONE SHALL always return to IDLE on the next edge.
REQ-020 result SHALL equal prod, hold its value in IDLE until the next accepted start, and change only during RUN.
REQ-021 alu_flags SHALL be {result[WIDTH-1], result==0, 1'b0, 1'b0}.
REQ-022 flag_write SHALL be 2'b10 when done=1 and the latched set_flags=1, and 2'b00 otherwise; C and V SHALL never be written.
REQ-023 start SHALL be ignored while busy=1; no queueing.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state, take priority over start, and suppress done; result keeps its partial value.
REQ-025 Inputs a, b, acc, accumulate and set_flags SHALL be sampled only on the start edge; later changes SHALL have no effect.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, result=0, alu_flags=4'b0100, flag_write=2'b00, cnt=0, latched set_flags=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no done SHALL follow after release.
REQ-028 The first start SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-029 A shared package mul_pkg SHALL hold the state enum (IDLE, RUN, DONE), the default width of 32, and the flag bit index constants (N=3, Z=2, C=1, V=0), shared with the condition/flag logic.
REQ-030 The iterative datapath (mcnd, mplr, prod, cnt registers and adder) SHALL be one sub-module, mul_datapath; FSM and flag generation SHALL stay in the top.

Verification
REQ-031 a=3, b=5, accumulate=0, set_flags=1 -> 3 iterations; done on 4th edge after start; result=15; alu_flags=4'b0000; flag_write=2'b10.
REQ-032 a=b=32'hFFFFFFFF, set_flags=0 -> 32 iterations; done on 33rd edge; result=32'h00000001; flag_write=2'b00.
REQ-033 a=1, b=32'h80000000, acc=32'h80000000, accumulate=1, set_flags=1 -> 32 iterations; result=0 (wrap); alu_flags=4'b0100; flag_write=2'b10.
REQ-034 b=0, a=7, accumulate=0, set_flags=1 -> 1 iteration; done on 2nd edge; result=0; alu_flags=4'b0100.
REQ-035 Start a=3, b=32'hFFFF, flush=1 plus start=1 at the 5th RUN edge -> IDLE next edge, no done, new start ignored; a later start a=2, b=2 gives result=4.
REQ-036 reset=0 in RUN cycle 10 -> busy, done, result, flag_write are 0 immediately; no done within 40 cycles after release without a new start.
